alu_op_sequencer: RTL and testbench
===================================

ALU_OP_SEQUENCER -- requirements
Module: alu_op_sequencer

Interface
REQ-001 Parameter ITER, default 32, meaning: iteration count for MUL/DIV; SHALL equal the operand width (32).
REQ-002 clock  input  1  rising-edge system clock.
REQ-003 clear  input  1  asynchronous, active-low reset; one clock domain only.
REQ-004 start  input  1  request strobe, sampled on the rising clock edge.
REQ-005 op  input  4  operation code: 0 AND, 1 OR, 2 ADD, 3 SUB, 4 SHR, 5 SHL, 6 ROR, 7 ROL, 8 NEG, 9 NOT, 10 MUL, 11 DIV, 12-15 illegal.
REQ-006 a_in  input  32  operand A (multiplicand or dividend).
REQ-007 b_in  input  32  operand B (multiplier or divisor).
REQ-008 alu_control  output  4  opcode driven to the external combinational ALU.
REQ-009 alu_a, alu_b  output  32 each  latched operands driven to the external ALU.
REQ-010 alu_result  input  32  low result returned combinationally by the external ALU.
REQ-011 z_lo_out, z_hi_out  output  32 each  registered result: low/quotient and high/remainder.
REQ-012 busy  output  1  operation in progress.
REQ-013 done  output  1  one-cycle result-valid pulse.
REQ-014 err  output  1  sticky-until-next-start error flag: divide-by-zero or illegal op.

Function
REQ-015 States SHALL be IDLE, EXEC, ITER, FIX and DONE; the state register and all outputs SHALL be registered.
REQ-016 In IDLE or DONE, start=1 SHALL latch op, a_in and b_in and clear err (edge E0); start SHALL be ignored in EXEC, ITER and FIX.
REQ-017 Ops 0-9 SHALL go IDLE->EXEC->DONE: alu_control/alu_a/alu_b are driven from latched values during EXEC, and at edge E0+1 z_lo_out=alu_result and z_hi_out=0.
REQ-018 For ops 0-9, done SHALL be high for exactly the cycle after edge E0+1.
REQ-019 MUL SHALL be a signed radix-2 Booth multiply of ITER iterations in ITER, followed by one FIX cycle; the 64-bit product SHALL go to {z_hi_out, z_lo_out}.
REQ-020 DIV SHALL be a restoring divide on magnitudes over ITER iterations; FIX SHALL apply signs: quotient negated when operand signs differ, remainder takes the dividend's sign.
REQ-021 DIV results SHALL be quotient in z_lo_out and remainder in z_hi_out.
REQ-022 MUL and DIV SHALL have fixed latency: results loaded at edge E0+ITER+1, done high in the following cycle.
REQ-023 DIV with b=0 SHALL skip ITER and go EXEC->DONE with z_lo_out=32'hFFFFFFFF, z_hi_out=dividend and err=1, using the same latency as REQ-017.
REQ-024 Ops 12-15 SHALL go EXEC->DONE with err=1 and z_lo_out/z_hi_out unchanged.
REQ-025 busy SHALL be 1 from edge E0 up to the edge that raises done; busy and done SHALL never both be 1.
REQ-026 start=1 during DONE SHALL begin a new operation back-to-back (DONE->EXEC/ITER), and done SHALL drop on that edge.
REQ-027 DONE with start=0 SHALL return to IDLE; z outputs SHALL hold until the next result load.
REQ-028 alu_control, alu_a and alu_b SHALL hold their last latched values outside EXEC.
REQ-029 The edge case -2^31 / -1 SHALL give quotient 32'h80000000 and remainder 0, with no err.

Reset
REQ-030 clear=0 SHALL at once, asynchronously, force IDLE and set z_lo_out, z_hi_out, alu_control, alu_a, alu_b, busy, done, err and the iteration counter to 0.
REQ-031 Assertion of clear mid-operation SHALL abort the operation with no done pulse; the first start after clear deasserts SHALL be accepted normally.

Verification
REQ-032 ADD: a=7, b=5, external ALU model -> z_lo_out=12, z_hi_out=0, done at cycle E0+2, busy high for exactly 1 cycle.
REQ-033 MUL: a=-3, b=0x40000000 -> {z_hi_out,z_lo_out}=64'hFFFFFFFF_40000000, done exactly ITER+2 cycles after E0.
REQ-034 DIV: a=-17, b=5 -> z_lo_out=-3, z_hi_out=-2, err=0; DIV with a=9, b=0 -> z_lo_out=FFFFFFFF, z_hi_out=9, err=1.
REQ-035 Back-to-back: SUB accepted on its done cycle followed by a second op -> two done pulses separated by no idle cycle; start pulses during busy are ignored.
REQ-036 clear asserted at iteration 10 of DIV -> all outputs 0 immediately, no done pulse; op=13 afterwards -> err=1, z unchanged.

Source files
------------

// File: rtl/alu_op_sequencer.sv
// Sequences single-cycle ops through an external ALU and runs
// Booth multiply / restoring divide internally over ITER steps.
// Ports: clock, clear (async low), start/op/a_in/b_in request,
//   alu_control/alu_a/alu_b to ALU, alu_result from ALU,
//   z_lo_out/z_hi_out result, busy/done/err status.
module alu_op_sequencer #(
   parameter int ITER = 32
) (
   input  logic        clock,
   input  logic        clear,
   input  logic        start,
   input  logic [3:0]  op,
   input  logic [31:0] a_in,
   input  logic [31:0] b_in,
   output logic [3:0]  alu_control,
   output logic [31:0] alu_a,
   output logic [31:0] alu_b,
   input  logic [31:0] alu_result,
   output logic [31:0] z_lo_out,
   output logic [31:0] z_hi_out,
   output logic        busy,
   output logic        done,
   output logic        err
);

   localparam int CW = $clog2(ITER + 1);
   localparam logic [3:0] OP_MUL = 4'd10;
   localparam logic [3:0] OP_DIV = 4'd11;

   typedef enum logic [2:0] {
      S_IDLE,
      S_EXEC,
      S_ITER,
      S_FIX,
      S_DONE
   } state_t;

   state_t state_q, state_d;

   logic [3:0]    ctl_d;
   logic [31:0]   a_d, b_d, lo_d, hi_d;
   logic          busy_d, done_d, err_d;

   // Shared iteration datapath:
   // MUL: acc = partial high, q = multiplier, q1 = Booth bit
   // DIV: acc = remainder, q = dividend/quotient bits
   logic [32:0]   acc_q, acc_d;
   logic [31:0]   q_q, q_d;
   logic          q1_q, q1_d;
   logic [31:0]   m_q, m_d;
   logic [CW-1:0] cnt_q, cnt_d;

   logic [31:0]   a_mag, b_mag;
   logic [32:0]   m_ext, booth_sum;
   logic [32:0]   div_sh;
   logic [33:0]   div_trial;
   logic          is_div;

   assign a_mag     = a_in[31] ? -a_in : a_in;
   assign b_mag     = b_in[31] ? -b_in : b_in;
   assign m_ext     = {m_q[31], m_q};
   assign div_sh    = {acc_q[31:0], q_q[31]};
   assign div_trial = {1'b0, div_sh} - {2'b00, m_q};
   assign is_div    = (alu_control == OP_DIV);

   always_comb begin
      booth_sum = acc_q;
      unique case ({q_q[0], q1_q})
         2'b01:   booth_sum = acc_q + m_ext;
         2'b10:   booth_sum = acc_q - m_ext;
         default: booth_sum = acc_q;
      endcase
   end

   always_comb begin
      state_d = state_q;
      ctl_d   = alu_control;
      a_d     = alu_a;
      b_d     = alu_b;
      lo_d    = z_lo_out;
      hi_d    = z_hi_out;
      busy_d  = busy;
      done_d  = done;
      err_d   = err;
      acc_d   = acc_q;
      q_d     = q_q;
      q1_d    = q1_q;
      m_d     = m_q;
      cnt_d   = cnt_q;

      unique case (state_q)
         S_IDLE, S_DONE: begin
            done_d  = 1'b0;
            state_d = S_IDLE;
            if (start) begin
               ctl_d  = op;
               a_d    = a_in;
               b_d    = b_in;
               err_d  = 1'b0;
               busy_d = 1'b1;
               cnt_d  = '0;
               acc_d  = '0;
               q1_d   = 1'b0;
               unique case (1'b1)
                  (op == OP_MUL): begin
                     q_d     = b_in;
                     m_d     = a_in;
                     state_d = S_ITER;
                  end
                  (op == OP_DIV && b_in != 32'd0): begin
                     q_d     = a_mag;
                     m_d     = b_mag;
                     state_d = S_ITER;
                  end
                  default: state_d = S_EXEC;
               endcase
            end
         end

         S_EXEC: begin
            state_d = S_DONE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            if (is_div) begin
               // only reached with a zero divisor
               lo_d  = 32'hFFFF_FFFF;
               hi_d  = alu_a;
               err_d = 1'b1;
            end else if (alu_control > OP_DIV) begin
               err_d = 1'b1;
            end else begin
               lo_d = alu_result;
               hi_d = 32'd0;
            end
         end

         S_ITER: begin
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == CW'(ITER - 1)) state_d = S_FIX;
            if (is_div) begin
               if (div_trial[33]) begin
                  acc_d = div_sh;
                  q_d   = {q_q[30:0], 1'b0};
               end else begin
                  acc_d = div_trial[32:0];
                  q_d   = {q_q[30:0], 1'b1};
               end
            end else begin
               {acc_d, q_d, q1_d} = {booth_sum[32], booth_sum, q_q};
            end
         end

         S_FIX: begin
            state_d = S_DONE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            if (is_div) begin
               lo_d = (alu_a[31] ^ alu_b[31]) ? -q_q : q_q;
               hi_d = alu_a[31] ? -acc_q[31:0] : acc_q[31:0];
            end else begin
               lo_d = q_q;
               hi_d = acc_q[31:0];
            end
         end

         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clock or negedge clear) begin
      if (!clear) state_q <= S_IDLE;
      else        state_q <= state_d;
   end

   always_ff @(posedge clock or negedge clear) begin
      if (!clear) begin
         alu_control <= '0;
         alu_a       <= '0;
         alu_b       <= '0;
         z_lo_out    <= '0;
         z_hi_out    <= '0;
         busy        <= 1'b0;
         done        <= 1'b0;
         err         <= 1'b0;
         acc_q       <= '0;
         q_q         <= '0;
         q1_q        <= 1'b0;
         m_q         <= '0;
         cnt_q       <= '0;
      end else begin
         alu_control <= ctl_d;
         alu_a       <= a_d;
         alu_b       <= b_d;
         z_lo_out    <= lo_d;
         z_hi_out    <= hi_d;
         busy        <= busy_d;
         done        <= done_d;
         err         <= err_d;
         acc_q       <= acc_d;
         q_q         <= q_d;
         q1_q        <= q1_d;
         m_q         <= m_d;
         cnt_q       <= cnt_d;
      end
   end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Directed bench for alu_op_sequencer with a behavioural
// external ALU; table vectors plus multi-cycle sequences.
module tb_alu_op_sequencer;

   logic        clock = 1'b0;
   logic        clear;
   logic        start;
   logic [3:0]  op;
   logic [31:0] a_in, b_in;
   logic [3:0]  alu_control;
   logic [31:0] alu_a, alu_b, alu_result;
   logic [31:0] z_lo_out, z_hi_out;
   logic        busy, done, err;

   int errors = 0;
   int checks = 0;

   always #5 clock = ~clock;

   alu_op_sequencer #(.ITER(32)) dut (
      .clock       (clock),
      .clear       (clear),
      .start       (start),
      .op          (op),
      .a_in        (a_in),
      .b_in        (b_in),
      .alu_control (alu_control),
      .alu_a       (alu_a),
      .alu_b       (alu_b),
      .alu_result  (alu_result),
      .z_lo_out    (z_lo_out),
      .z_hi_out    (z_hi_out),
      .busy        (busy),
      .done        (done),
      .err         (err)
   );

   // external combinational ALU
   always_comb begin
      int s;
      s = int'(alu_b[4:0]);
      alu_result = 32'd0;
      case (alu_control)
         4'd0: alu_result = alu_a & alu_b;
         4'd1: alu_result = alu_a | alu_b;
         4'd2: alu_result = alu_a + alu_b;
         4'd3: alu_result = alu_a - alu_b;
         4'd4: alu_result = alu_a >> s;
         4'd5: alu_result = alu_a << s;
         4'd6: alu_result = (alu_a >> s) | (alu_a << (32 - s));
         4'd7: alu_result = (alu_a << s) | (alu_a >> (32 - s));
         4'd8: alu_result = -alu_a;
         4'd9: alu_result = ~alu_a;
         default: alu_result = 32'd0;
      endcase
   end

   typedef struct {
      logic [3:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] lo;
      logic [31:0] hi;
      logic        err;
      int          lat;
   } vec_t;

   vec_t vecs[20];

   task automatic check(input string name, input logic [63:0] act,
                        input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // waits (bounded) for done; returns edges counted after E0
   task automatic wait_done(output int n);
      n = 0;
      while (!done && n < 100) begin
         @(posedge clock); #1;
         n++;
      end
   endtask

   task automatic launch(input logic [3:0] o, input logic [31:0] a,
                         input logic [31:0] b);
      @(negedge clock);
      op = o; a_in = a; b_in = b; start = 1'b1;
      @(posedge clock); #1;
      start = 1'b0;
   endtask

   initial begin
      int n;
      int dcount;

      vecs[0]  = '{4'd2,  32'd7,        32'd5,        32'd12,       32'd0,        1'b0, 1};
      vecs[1]  = '{4'd0,  32'hF0F01234, 32'h0FF0FFFF, 32'h00F01234, 32'd0,        1'b0, 1};
      vecs[2]  = '{4'd1,  32'h00FF0000, 32'h0000FF00, 32'h00FFFF00, 32'd0,        1'b0, 1};
      vecs[3]  = '{4'd3,  32'd5,        32'd7,        32'hFFFFFFFE, 32'd0,        1'b0, 1};
      vecs[4]  = '{4'd4,  32'h80000000, 32'd4,        32'h08000000, 32'd0,        1'b0, 1};
      vecs[5]  = '{4'd5,  32'd1,        32'd31,       32'h80000000, 32'd0,        1'b0, 1};
      vecs[6]  = '{4'd6,  32'd1,        32'd1,        32'h80000000, 32'd0,        1'b0, 1};
      vecs[7]  = '{4'd7,  32'h80000001, 32'd4,        32'h00000018, 32'd0,        1'b0, 1};
      vecs[8]  = '{4'd8,  32'd5,        32'd0,        32'hFFFFFFFB, 32'd0,        1'b0, 1};
      vecs[9]  = '{4'd9,  32'd0,        32'd0,        32'hFFFFFFFF, 32'd0,        1'b0, 1};
      vecs[10] = '{4'd10, 32'hFFFFFFFD, 32'h40000000, 32'h40000000, 32'hFFFFFFFF, 1'b0, 33};
      vecs[11] = '{4'd10, 32'd7,        32'hFFFFFFFA, 32'hFFFFFFD6, 32'hFFFFFFFF, 1'b0, 33};
      vecs[12] = '{4'd10, 32'h80000000, 32'h80000000, 32'd0,        32'h40000000, 1'b0, 33};
      vecs[13] = '{4'd11, 32'hFFFFFFEF, 32'd5,        32'hFFFFFFFD, 32'hFFFFFFFE, 1'b0, 33};
      vecs[14] = '{4'd11, 32'd9,        32'd0,        32'hFFFFFFFF, 32'd9,        1'b1, 1};
      vecs[15] = '{4'd11, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'd0,        1'b0, 33};
      vecs[16] = '{4'd11, 32'd100,      32'd7,        32'd14,       32'd2,        1'b0, 33};
      vecs[17] = '{4'd11, 32'd17,       32'hFFFFFFFB, 32'hFFFFFFFD, 32'd2,        1'b0, 33};
      vecs[18] = '{4'd14, 32'd1,        32'd2,        32'hFFFFFFFD, 32'd2,        1'b1, 1};
      vecs[19] = '{4'd10, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd1,        32'd0,        1'b0, 33};

      clear = 1'b1; start = 1'b0; op = '0; a_in = '0; b_in = '0;
      #3 clear = 1'b0;
      #1;
      check("rst z_lo", 64'(z_lo_out), 64'd0);
      check("rst busy/done/err", {busy, done, err}, 3'b000);
      check("rst alu_ctl", 64'(alu_control), 64'd0);
      repeat (2) @(posedge clock);
      @(negedge clock) clear = 1'b1;

      for (int i = 0; i < 20; i++) begin
         launch(vecs[i].op, vecs[i].a, vecs[i].b);
         check($sformatf("v%0d busy@E0", i), {busy, done}, 2'b10);
         wait_done(n);
         check($sformatf("v%0d lat", i), 64'(n), 64'(vecs[i].lat));
         check($sformatf("v%0d lo", i), 64'(z_lo_out), 64'(vecs[i].lo));
         check($sformatf("v%0d hi", i), 64'(z_hi_out), 64'(vecs[i].hi));
         check($sformatf("v%0d err", i), 64'(err), 64'(vecs[i].err));
         check($sformatf("v%0d busy@done", i), 64'(busy), 64'd0);
         @(posedge clock); #1;
         check($sformatf("v%0d done drop", i), 64'(done), 64'd0);
      end

      // back-to-back: SUB, then ADD accepted on SUB's done cycle
      launch(4'd3, 32'd10, 32'd3);
      wait_done(n);
      check("b2b sub lo", 64'(z_lo_out), 64'd7);
      op = 4'd2; a_in = 32'd1; b_in = 32'd2; start = 1'b1;
      @(posedge clock); #1;
      start = 1'b0;
      check("b2b E0 busy/done", {busy, done}, 2'b10);
      @(posedge clock); #1;
      check("b2b add done", 64'(done), 64'd1);
      check("b2b add lo", 64'(z_lo_out), 64'd3);
      @(posedge clock); #1;

      // start held during busy must be ignored
      launch(4'd10, 32'd2, 32'd3);
      op = 4'd2; a_in = 32'd99; b_in = 32'd1; start = 1'b1;
      repeat (20) @(posedge clock);
      #1 start = 1'b0;
      wait_done(n);
      check("ign lat", 64'(n + 20), 64'd33);
      check("ign lo", 64'(z_lo_out), 64'd6);
      check("ign alu_a", 64'(alu_a), 64'd2);
      @(posedge clock); #1;

      // clear asserted mid-divide
      launch(4'd11, 32'd100, 32'd7);
      repeat (10) @(posedge clock);
      #2 clear = 1'b0;
      #1;
      check("clr z", {z_hi_out, z_lo_out}, 64'd0);
      check("clr alu", {alu_a, alu_b}, 64'd0);
      check("clr flags", {alu_control, busy, done, err}, 7'd0);
      dcount = 0;
      for (int k = 0; k < 40; k++) begin
         @(posedge clock); #1;
         if (done) dcount++;
      end
      check("clr no done", 64'(dcount), 64'd0);
      @(negedge clock) clear = 1'b1;
      launch(4'd13, 32'd5, 32'd6);
      wait_done(n);
      check("post clr lat", 64'(n), 64'd1);
      check("post clr err", 64'(err), 64'd1);
      check("post clr z", {z_hi_out, z_lo_out}, 64'd0);
      @(posedge clock); #1;
      check("idle hold z", {z_hi_out, z_lo_out, 1'(done)}, 65'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
